pll_reset_sequencer: RTL and testbench

PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

---
 rtl/pll_reset_sequencer.sv | 133 +++++++++++++
 tb/tb_pll_reset_sequencer.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// PLL lock qualifier and downstream reset sequencer: synchronizes the raw lock,
// qualifies it, holds reset a little longer, then releases and emits a baud tick.
module pll_reset_sequencer #(
  parameter int LOCK_CYCLES = 1024,
  parameter int RST_HOLD    = 16,
  parameter int TICK_DIV    = 125
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       clear_lost,
  output logic       sys_rst_n,
  output logic       ready,
  output logic       tick,
  output logic       lock_lost,
  output logic [7:0] loss_count
);
  localparam int MAXC = (LOCK_CYCLES > RST_HOLD) ? LOCK_CYCLES : RST_HOLD;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int TW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(RST_HOLD - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  typedef enum logic [1:0] {WAIT_LOCK, QUALIFY, HOLD, RUN} state_t;

  state_t        state, nxt;
  logic [1:0]    sync_pipe;
  logic          locked_s;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [TW-1:0] tcnt;
  logic          loss;
  logic          run_stay;

  assign locked_s = sync_pipe[1];
  assign loss     = (state == RUN) && !locked_s;
  assign run_stay = (state == RUN) && (nxt == RUN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_pipe <= '0;
    else      sync_pipe <= {sync_pipe[0], pll_locked};
  end

  always_comb begin
    nxt     = state;
    cnt_nxt = cnt;
    case (state)
      WAIT_LOCK: begin
        cnt_nxt = '0;
        if (locked_s) nxt = QUALIFY;
      end
      QUALIFY: begin
        if (!locked_s) begin
          nxt     = WAIT_LOCK;
          cnt_nxt = '0;
        end else if (cnt == LOCK_LAST) begin
          nxt     = HOLD;
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      HOLD: begin
        if (!locked_s) begin
          nxt     = WAIT_LOCK;
          cnt_nxt = '0;
        end else if (cnt == HOLD_LAST) begin
          nxt     = RUN;
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RUN: begin
        cnt_nxt = '0;
        if (!locked_s) nxt = WAIT_LOCK;
      end
      default: begin
        nxt     = WAIT_LOCK;
        cnt_nxt = '0;
      end
    endcase
  end

  // Reset/ready are decoded from the next state so they move on the state edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= WAIT_LOCK;
      cnt       <= '0;
      sys_rst_n <= 1'b0;
      ready     <= 1'b0;
    end else begin
      state     <= nxt;
      cnt       <= cnt_nxt;
      sys_rst_n <= (nxt == RUN);
      ready     <= (nxt == RUN);
    end
  end

  // Tick divider runs only while RUN persists, so the first pulse lands TICK_DIV after release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tcnt <= '0;
      tick <= 1'b0;
    end else if (run_stay) begin
      if (tcnt == TICK_LAST) begin
        tcnt <= '0;
        tick <= 1'b1;
      end else begin
        tcnt <= tcnt + 1'b1;
        tick <= 1'b0;
      end
    end else begin
      tcnt <= '0;
      tick <= 1'b0;
    end
  end

  // A loss on the same edge as a clear restarts the count at one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock_lost  <= 1'b0;
      loss_count <= '0;
    end else if (loss) begin
      lock_lost  <= 1'b1;
      loss_count <= clear_lost ? 8'd1 :
                    (loss_count == 8'hFF) ? 8'hFF : loss_count + 8'd1;
    end else if (clear_lost) begin
      lock_lost  <= 1'b0;
      loss_count <= '0;
    end
  end
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed plus randomized lock patterns against a run-length reference model.
module tb_pll_reset_sequencer;
  localparam int L  = 8;
  localparam int R  = 4;
  localparam int TD = 5;

  logic       clk = 1'b0;
  logic       rst, pll_locked, clear_lost;
  logic       sys_rst_n, ready, tick, lock_lost;
  logic [7:0] loss_count;

  int checks = 0;
  int errors = 0;

  // Model state: run length of raw-high samples over the last three edges.
  int h0, h1, h2;
  bit m_ready, m_lost, m_tick;
  int m_run, m_cnt;

  pll_reset_sequencer #(.LOCK_CYCLES(L), .RST_HOLD(R), .TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .pll_locked(pll_locked), .clear_lost(clear_lost),
    .sys_rst_n(sys_rst_n), .ready(ready), .tick(tick),
    .lock_lost(lock_lost), .loss_count(loss_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".sys_rst_n"}, {31'd0, sys_rst_n}, {31'd0, m_ready});
    chk({tag, ".ready"},     {31'd0, ready},     {31'd0, m_ready});
    chk({tag, ".tick"},      {31'd0, tick},      {31'd0, m_tick});
    chk({tag, ".lock_lost"}, {31'd0, lock_lost}, {31'd0, m_lost});
    chk({tag, ".loss_count"}, {24'd0, loss_count}, m_cnt);
  endtask

  task automatic model_reset();
    h0 = 0; h1 = 0; h2 = 0;
    m_ready = 0; m_lost = 0; m_tick = 0; m_run = 0; m_cnt = 0;
  endtask

  // One clock: drive, let the edge happen, advance the model, compare everything.
  task automatic cyc(input bit lk, input bit clr);
    bit nr, loss;
    pll_locked = lk;
    clear_lost = clr;
    @(posedge clk); #1;
    h2 = h1; h1 = h0;
    h0 = lk ? ((h0 < 1000000) ? h0 + 1 : h0) : 0;
    nr   = (h2 >= L + R + 1);
    loss = m_ready && !nr;
    if (loss) begin
      m_lost = 1;
      m_cnt  = clr ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
    end else if (clr) begin
      m_lost = 0;
      m_cnt  = 0;
    end
    m_ready = nr;
    m_run   = m_ready ? m_run + 1 : 0;
    m_tick  = (m_run > 1) && (((m_run - 1) % TD) == 0);
    chk_all("cyc");
  endtask

  // Assert reset between edges and confirm outputs clear without a clock edge.
  task automatic async_rst(input string tag);
    #3 rst = 1'b0;
    #1;
    model_reset();
    chk_all(tag);
    @(posedge clk); @(posedge clk); #1;
    chk_all({tag, "_held"});
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; pll_locked = 1'b0; clear_lost = 1'b0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    chk_all("reset");
    rst = 1'b1;

    // Lock from release: release on edge L+R+3, ticks every TD after.
    for (int i = 1; i <= L + R + 3 + 3 * TD; i++) begin
      cyc(1, 0);
      if (i == L + R + 2) chk("pre_release", {31'd0, sys_rst_n}, 32'd0);
      if (i == L + R + 3) chk("release", {31'd0, sys_rst_n}, 32'd1);
      if (i == L + R + 3 + TD) chk("first_tick", {31'd0, tick}, 32'd1);
    end

    // Drop in RUN: low three edges after the sampling edge, then relock.
    cyc(0, 0);
    cyc(1, 0);
    chk("drop_edge2", {31'd0, sys_rst_n}, 32'd1);
    cyc(1, 0);
    chk("drop_edge3", {31'd0, sys_rst_n}, 32'd0);
    chk("drop_lost", {31'd0, lock_lost}, 32'd1);
    chk("drop_cnt", {24'd0, loss_count}, 32'd1);
    for (int i = 0; i < L + R + 6; i++) cyc(1, 0);
    chk("relock", {31'd0, ready}, 32'd1);

    // Coincident clear and loss: loss wins with count restarting at one.
    cyc(0, 0); cyc(1, 0); cyc(1, 1);
    chk("coinc_lost", {31'd0, lock_lost}, 32'd1);
    chk("coinc_cnt", {24'd0, loss_count}, 32'd1);

    // Glitch during QUALIFY after reset: no loss recorded, full delay restarts.
    async_rst("rst_run");
    for (int i = 0; i < 5; i++) cyc(1, 0);
    cyc(0, 0);
    for (int i = 0; i < L + R + 8; i++) cyc(1, 0);
    chk("glitch_lost", {31'd0, lock_lost}, 32'd0);

    // Saturation over 300 RUN drops, then clear.
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < L + R + 5; i++) cyc(1, 0);
      cyc(0, 0);
    end
    cyc(1, 0); cyc(1, 0);
    chk("sat_cnt", {24'd0, loss_count}, 32'd255);
    cyc(1, 1);
    chk("clr_lost", {31'd0, lock_lost}, 32'd0);
    chk("clr_cnt", {24'd0, loss_count}, 32'd0);

    // Reset while in HOLD, then restart.
    async_rst("rst_pre");
    for (int i = 0; i < L + 4; i++) cyc(1, 0);
    async_rst("rst_hold");
    for (int i = 0; i < L + R + 6; i++) cyc(1, 0);

    // Randomized lock patterns with sporadic clears.
    for (int s = 0; s < 150; s++) begin
      int hl, ll;
      hl = $urandom_range(1, 24);
      for (int i = 0; i < hl; i++) cyc(1, $urandom_range(0, 15) == 0);
      ll = $urandom_range(1, 3);
      for (int i = 0; i < ll; i++) cyc(0, $urandom_range(0, 7) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
